cdb_arbiter: RTL and testbench

Collects finished results from NUM_UNITS execution units and broadcasts up to two per cycle on the dual common data bus lanes consumed by the reservation stations, register file and reorder logic. Each unit owns a one-entry holding buffer behind a valid/ready handshake. Buffers are granted round-robin. Speculative (tagged) results are discarded on `delete_tag` and promoted on `clear_tag`.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_pick.sv | 37 +++
 rtl/cdb_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the dual-lane common data bus arbiter.
package cdb_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 6;
    localparam int LANES  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  arn;
        logic [REG_W-1:0]  rrn;
        logic              tag;
    } cdb_entry_t;

    // A lane register reuses the tag slot as its valid flag: speculation
    // state is never broadcast, so the slot is free once a grant is made.
    function automatic cdb_entry_t to_lane(input logic grant,
                                           input cdb_entry_t e);
        cdb_entry_t l;
        l = '0;
        if (grant) begin
            l     = e;
            l.tag = 1'b1;
        end
        return l;
    endfunction

endpackage

// File: rtl/cdb_arbiter_pick.sv
// Cyclic find-first-set: first set mask bit at or after start,
// optionally ignoring one index.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    input  logic         skip_en,
    input  logic [W-1:0] skip,
    output logic         found,
    output logic [W-1:0] index
);

    logic [W:0]   pos;
    logic [W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        cand  = '0;
        // Scan from the far end so the nearest hit is written last.
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (W+1)'(k);
            if (pos >= (W+1)'(N)) begin
                pos = pos - (W+1)'(N);
            end
            cand = pos[W-1:0];
            if (mask[cand] && !(skip_en && cand == skip)) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Dual-lane CDB arbiter: one-entry buffer per unit, round-robin grant,
// tag flush/promote. Counters enabled by CDB_ARBITER_STATS_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              delete_tag,
    input  logic                              clear_tag,
    input  logic [NUM_UNITS-1:0]              unit_valid,
    output logic [NUM_UNITS-1:0]              unit_ready,
    input  logic [NUM_UNITS-1:0][DATA_W-1:0]  unit_result,
    input  logic [NUM_UNITS-1:0][REG_W-1:0]   unit_arn,
    input  logic [NUM_UNITS-1:0][REG_W-1:0]   unit_rrn,
    input  logic [NUM_UNITS-1:0]              unit_tag,
    output logic [LANES-1:0]                  cdb_valid,
    output logic [LANES-1:0][DATA_W-1:0]      cdb_result,
    output logic [LANES-1:0][REG_W-1:0]       cdb_arn,
    output logic [LANES-1:0][REG_W-1:0]       cdb_rrn,
    output logic [31:0]                       stat_broadcasts,
    output logic [31:0]                       stat_stalls
);

    localparam int PW = $clog2(NUM_UNITS);

    cdb_entry_t           buf_q [NUM_UNITS];
    cdb_entry_t           lane_q [LANES];
    logic [NUM_UNITS-1:0] buf_valid;
    logic [NUM_UNITS-1:0] buf_tag;
    logic [NUM_UNITS-1:0] live;
    logic [NUM_UNITS-1:0] granted;
    logic [NUM_UNITS-1:0] dropped;
    logic [NUM_UNITS-1:0] store;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        pick0;
    logic [PW-1:0]        pick1;
    logic [PW-1:0]        after0;
    logic                 found0;
    logic                 hit1;
    logic                 found1;
    logic                 flush;
    logic                 promote;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (i == PW'(NUM_UNITS - 1)) ? '0 : i + PW'(1);
    endfunction

    assign flush   = delete_tag;
    assign promote = clear_tag & ~delete_tag;

    always_comb begin
        buf_tag = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            buf_tag[i] = buf_q[i].tag;
        end
    end

    assign live    = buf_valid & ~(buf_tag & {NUM_UNITS{flush}});
    assign dropped = unit_tag & {NUM_UNITS{flush}};

    rr_pick #(.N(NUM_UNITS), .W(PW)) u_pick0 (
        .mask    (live),
        .start   (rr_ptr),
        .skip_en (1'b0),
        .skip    ('0),
        .found   (found0),
        .index   (pick0)
    );

    assign after0 = wrap_inc(pick0);

    rr_pick #(.N(NUM_UNITS), .W(PW)) u_pick1 (
        .mask    (live),
        .start   (after0),
        .skip_en (1'b1),
        .skip    (pick0),
        .found   (hit1),
        .index   (pick1)
    );

    assign found1 = found0 & hit1;

    always_comb begin
        granted = '0;
        if (found0) begin
            granted[pick0] = 1'b1;
        end
        if (found1) begin
            granted[pick1] = 1'b1;
        end
    end

    // Tagged results arriving during a flush are swallowed, never stored.
    assign unit_ready = ~buf_valid | granted | dropped;
    assign store      = unit_valid & unit_ready & ~dropped;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (store[i]) begin
                    buf_valid[i] <= 1'b1;
                    buf_q[i]     <= '{result: unit_result[i],
                                      arn:    unit_arn[i],
                                      rrn:    unit_rrn[i],
                                      tag:    unit_tag[i] & ~promote};
                end else if (granted[i] || (flush && buf_tag[i])) begin
                    buf_valid[i] <= 1'b0;
                end else if (promote) begin
                    buf_q[i].tag <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            lane_q[0] <= '0;
            lane_q[1] <= '0;
        end else begin
            if (found1) begin
                rr_ptr <= wrap_inc(pick1);
            end else if (found0) begin
                rr_ptr <= after0;
            end
            lane_q[0] <= to_lane(found0, buf_q[pick0]);
            lane_q[1] <= to_lane(found1, buf_q[pick1]);
        end
    end

    always_comb begin
        cdb_valid  = '0;
        cdb_result = '0;
        cdb_arn    = '0;
        cdb_rrn    = '0;
        for (int l = 0; l < LANES; l++) begin
            cdb_valid[l]  = lane_q[l].tag;
            cdb_result[l] = lane_q[l].result;
            cdb_arn[l]    = lane_q[l].arn;
            cdb_rrn[l]    = lane_q[l].rrn;
        end
    end

`ifdef CDB_ARBITER_STATS_EN
    logic [31:0] bcast_q;
    logic [31:0] stall_q;
    logic        stall;

    assign stall = |(live & ~granted);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcast_q <= '0;
            stall_q <= '0;
        end else begin
            bcast_q <= bcast_q + 32'(lane_q[0].tag) + 32'(lane_q[1].tag);
            stall_q <= stall_q + 32'(stall);
        end
    end

    assign stat_broadcasts = bcast_q;
    assign stat_stalls     = stall_q;
`else
    assign stat_broadcasts = '0;
    assign stat_stalls     = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: unit sources fed from per-unit
// queues, expected broadcasts queued in grant order.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NU = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  delete_tag;
    logic                  clear_tag;
    logic [NU-1:0]         unit_valid;
    logic [NU-1:0]         unit_ready;
    logic [NU-1:0][31:0]   unit_result;
    logic [NU-1:0][5:0]    unit_arn;
    logic [NU-1:0][5:0]    unit_rrn;
    logic [NU-1:0]         unit_tag;
    logic [1:0]            cdb_valid;
    logic [1:0][31:0]      cdb_result;
    logic [1:0][5:0]       cdb_arn;
    logic [1:0][5:0]       cdb_rrn;
    logic [31:0]           stat_broadcasts;
    logic [31:0]           stat_stalls;

    cdb_entry_t    src_mem [NU][32];
    int            src_head [NU];
    int            src_tail [NU];
    logic [43:0]   exp_q [$];
    int            ucnt [NU];
    int            mon_bcast;
    logic [NU-1:0] last_ready;
    int            total;
    int            bad;

    cdb_arbiter #(.NUM_UNITS(NU)) dut (
        .clock           (clock),
        .reset           (reset),
        .delete_tag      (delete_tag),
        .clear_tag       (clear_tag),
        .unit_valid      (unit_valid),
        .unit_ready      (unit_ready),
        .unit_result     (unit_result),
        .unit_arn        (unit_arn),
        .unit_rrn        (unit_rrn),
        .unit_tag        (unit_tag),
        .cdb_valid       (cdb_valid),
        .cdb_result      (cdb_result),
        .cdb_arn         (cdb_arn),
        .cdb_rrn         (cdb_rrn),
        .stat_broadcasts (stat_broadcasts),
        .stat_stalls     (stat_stalls)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic send(input int u, input logic [31:0] r,
                        input logic [5:0] a, input logic [5:0] p,
                        input logic t, input logic seen);
        src_mem[u][src_tail[u]] = '{result: r, arn: a, rrn: p, tag: t};
        src_tail[u]++;
        if (seen) exp_q.push_back({r, a, p});
    endtask

    function automatic logic pending();
        logic any;
        any = 1'b0;
        for (int u = 0; u < NU; u++) begin
            if (src_head[u] < src_tail[u]) any = 1'b1;
        end
        return any;
    endfunction

    task automatic step(input logic del, input logic clr);
        logic [NU-1:0] acc;
        cdb_entry_t    e;
        @(negedge clock);
        delete_tag = del;
        clear_tag  = clr;
        for (int u = 0; u < NU; u++) begin
            e = '0;
            unit_valid[u] = 1'b0;
            if (src_head[u] < src_tail[u]) begin
                e = src_mem[u][src_head[u]];
                unit_valid[u] = 1'b1;
            end
            unit_result[u] = e.result;
            unit_arn[u]    = e.arn;
            unit_rrn[u]    = e.rrn;
            unit_tag[u]    = e.tag;
        end
        #1;
        acc        = unit_valid & unit_ready;
        last_ready = unit_ready;
        @(posedge clock);
        for (int u = 0; u < NU; u++) begin
            if (acc[u]) src_head[u]++;
        end
        #1;
        unit_valid = '0;
        delete_tag = 1'b0;
        clear_tag  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((pending() || exp_q.size() != 0) && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        mon_bcast = 0;
    endtask

    always @(negedge clock) begin
        logic [43:0] got;
        logic [43:0] want;
        if (!reset) begin
            if (cdb_valid[1]) check("lane1_alone", cdb_valid[0], 1);
            for (int l = 0; l < 2; l++) begin
                got = {cdb_result[l], cdb_arn[l], cdb_rrn[l]};
                if (!cdb_valid[l]) begin
                    check("idle_zero", got, 0);
                end else if (exp_q.size() == 0) begin
                    check("cdb_unexpected", cdb_valid[l], 0);
                end else begin
                    want = exp_q.pop_front();
                    check("cdb_data", got, want);
                    mon_bcast++;
                    ucnt[cdb_arn[l][1:0]]++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base [NU];
`ifdef CDB_ARBITER_STATS_EN
        logic [31:0] st0;
`endif
        total = 0;
        bad   = 0;
        mon_bcast = 0;
        for (int u = 0; u < NU; u++) begin
            src_head[u] = 0;
            src_tail[u] = 0;
            ucnt[u]     = 0;
        end
        delete_tag  = 1'b0;
        clear_tag   = 1'b0;
        unit_valid  = '0;
        unit_result = '0;
        unit_arn    = '0;
        unit_rrn    = '0;
        unit_tag    = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", cdb_valid, 0);
        check("rst_ready", unit_ready, 4'hF);
        check("rst_bcast", stat_broadcasts, 0);
        check("rst_stall", stat_stalls, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // single source, latency and exact values
        send(2, 32'hDEADBEEF, 6'd5, 6'd37, 1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("lat_e0", cdb_valid, 2'b00);
        step(1'b0, 1'b0);
        check("lat_e1", cdb_valid, 2'b01);
        check("single_res", cdb_result[0], 32'hDEADBEEF);
        check("single_arn", cdb_arn[0], 5);
        check("single_rrn", cdb_rrn[0], 37);
        check("single_l1", cdb_arn[1], 0);

        // pointer now 3: unit 3 before unit 0
        send(3, 32'h3333, 6'd3, 6'd13, 1'b0, 1'b1);
        send(0, 32'h1000, 6'd0, 6'd10, 1'b0, 1'b1);
        drain("ptr_drain");

        // all four from pointer 0
        do_reset();
`ifdef CDB_ARBITER_STATS_EN
        st0 = stat_stalls;
`endif
        for (int u = 0; u < NU; u++) begin
            send(u, 32'hA0 + u, 6'(u), 6'(20 + u), 1'b0, 1'b1);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("c1_ready", last_ready, 4'b0011);
        check("c1_lanes", cdb_valid, 2'b11);
        step(1'b0, 1'b0);
        check("c2_ready", last_ready, 4'b1111);
        check("c2_lanes", cdb_valid, 2'b11);
        drain("four_drain");
`ifdef CDB_ARBITER_STATS_EN
        check("four_stall", stat_stalls - st0, 1);
`endif

        // fairness: continuous streaming
        for (int u = 0; u < NU; u++) base[u] = ucnt[u];
        for (int n = 0; n < 4; n++) begin
            for (int u = 0; u < NU; u++) begin
                send(u, {24'hF00, 4'(n), 4'(u)}, 6'(u), 6'(40 + u),
                     1'b0, 1'b1);
            end
        end
        drain("fair_drain");
        for (int u = 0; u < NU; u++) begin
            check($sformatf("fair_u%0d", u), ucnt[u] - base[u], 4);
        end

        // flush: tagged buffers dropped, untagged survives
        send(0, 32'hBAD0, 6'd1, 6'd1, 1'b1, 1'b0);
        send(1, 32'hBAD1, 6'd1, 6'd2, 1'b1, 1'b0);
        send(2, 32'h600D, 6'd2, 6'd22, 1'b0, 1'b1);
        step(1'b0, 1'b0);
        send(3, 32'hBAD3, 6'd3, 6'd3, 1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("flush_rdy3", last_ready[3], 1);
        drain("flush_drain");

        // delete wins over clear; clear alone protects later entry
        send(0, 32'hBAD4, 6'd4, 6'd4, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        send(1, 32'hC1EA, 6'd6, 6'd26, 1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        drain("clr_drain");
        repeat (3) step(1'b0, 1'b0);

`ifdef CDB_ARBITER_STATS_EN
        check("stat_bcast", stat_broadcasts, mon_bcast);
`else
        check("stat_bcast", stat_broadcasts, 0);
        check("stat_stall", stat_stalls, 0);
`endif

        // reset with units 0 and 1 still buffered (pointer at 2)
        for (int u = 0; u < NU; u++) begin
            send(u, 32'h5000 + u, 6'(u), 6'(50 + u), 1'b0, u >= 2);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", cdb_valid, 0);
        check("mid_rst_res", cdb_result[0], 0);
        check("mid_rst_ready", unit_ready, 4'hF);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", unit_ready, 4'hF);
        repeat (4) step(1'b0, 1'b0);
        check("post_rst_q", exp_q.size(), 0);
        check("post_rst_valid", cdb_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
